// File: rtl/bch_enc_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bch_enc_stream : streaming systematic BCH encoder, W bits per beat.         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module bch_enc_stream #(
    parameter int            K   = 51,
    parameter int            P   = 12,
    parameter logic [P-1:0]  GEN = 12'h539,
    parameter int            W   = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync_clr,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    output logic          m_last,
    output logic          busy
);

    localparam int c_nb   = K / W;
    localparam int c_np   = (P + W - 1) / W;
    localparam int c_pw   = c_np * W;
    localparam int c_cmax = (c_nb > c_np) ? c_nb : c_np;
    localparam int c_cw   = (c_cmax > 1) ? $clog2(c_cmax) : 1;

    if ((K % W) != 0) begin : g_k_check
        $error("bch_enc_stream: K must be a multiple of W");
    end

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_PAR  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [P-1:0]    r_rem;
    logic [c_cw-1:0] r_cnt;
    logic            r_mvalid;
    logic [W-1:0]    r_mdata;
    logic            r_mlast;
    logic            r_busy;
    logic            r_en;

    logic            w_load_ok;
    logic            w_s_ready;
    logic            w_par_load;
    logic            w_accept;
    logic            w_data_last;
    logic            w_par_last;
    logic [P-1:0]    w_rem_nxt;
    logic [c_pw-1:0] w_par_pad;
    logic [W-1:0]    w_par_beat;

    // One LFSR step per message bit, MSB of the beat first.
    function automatic logic [P-1:0] f_lfsr(input logic [P-1:0] rem, input logic [W-1:0] beat);
        logic [P-1:0] r;
        logic         fb;
        r = rem;
        for (int i = W - 1; i >= 0; i--) begin
            fb = beat[i] ^ r[P-1];
            r  = (r << 1) ^ (fb ? GEN : '0);
        end
        return r;
    endfunction

    assign w_load_ok   = ~r_mvalid | m_ready;
    assign w_data_last = (r_cnt == c_cw'(c_nb - 1));
    assign w_par_last  = (r_cnt == c_cw'(c_np - 1));
    assign w_accept    = s_valid & w_s_ready;
    assign w_rem_nxt   = f_lfsr(r_rem, s_data);

    // Remainder left-aligned into whole beats; unused low bits stay zero.
    always_comb begin
        w_par_pad = '0;
        w_par_pad[c_pw-1 -: P] = r_rem;
    end

    always_comb begin
        w_par_beat = '0;
        for (int i = 0; i < c_np; i++) begin
            if (r_cnt == c_cw'(i)) begin
                w_par_beat = w_par_pad[c_pw-1-i*W -: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_DATA;
        end else if (sync_clr) begin
            r_state <= ST_DATA;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_par_load  = 1'b0;
        case (r_state)
            ST_DATA: begin
                w_s_ready = r_en & w_load_ok;
                if (s_valid && r_en && w_load_ok && w_data_last) begin
                    w_state_nxt = ST_PAR;
                end
            end
            ST_PAR: begin
                w_par_load = w_load_ok;
                if (w_load_ok && w_par_last) begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: w_state_nxt = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_cnt    <= '0;
            r_mvalid <= 1'b0;
            r_mdata  <= '0;
            r_mlast  <= 1'b0;
            r_busy   <= 1'b0;
            r_en     <= 1'b0;
        end else if (sync_clr) begin
            r_rem    <= '0;
            r_cnt    <= '0;
            r_mvalid <= 1'b0;
            r_mdata  <= '0;
            r_mlast  <= 1'b0;
            r_busy   <= 1'b0;
            r_en     <= 1'b0;
        end else begin
            r_en <= 1'b1;
            if (w_accept) begin
                r_rem    <= w_rem_nxt;
                r_mdata  <= s_data;
                r_mvalid <= 1'b1;
                r_mlast  <= 1'b0;
                r_cnt    <= w_data_last ? '0 : r_cnt + 1'b1;
            end else if (w_par_load) begin
                r_mdata  <= w_par_beat;
                r_mvalid <= 1'b1;
                r_mlast  <= w_par_last;
                if (w_par_last) begin
                    r_rem <= '0;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_load_ok) begin
                r_mvalid <= 1'b0;
                r_mlast  <= 1'b0;
            end
            // A new codeword accepted as the old one drains keeps busy high.
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_mvalid && m_ready && r_mlast) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign s_ready = w_s_ready;
    assign m_valid = r_mvalid;
    assign m_data  = r_mdata;
    assign m_last  = r_mlast;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bch_enc_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bch_enc_stream : directed and randomised checks of bch_enc_stream.      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bch_enc_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters (K=51, P=12, W=17)
    logic        a_rst_n = 1'b1;
    logic        a_sync_clr = 1'b0;
    logic        a_s_valid = 1'b0;
    logic        a_s_ready;
    logic [16:0] a_s_data = '0;
    logic        a_m_valid;
    logic        a_m_ready = 1'b0;
    logic [16:0] a_m_data;
    logic        a_m_last;
    logic        a_busy;

    // Instance B: K=63, P=12, W=7
    logic        b_rst_n = 1'b1;
    logic        b_sync_clr = 1'b0;
    logic        b_s_valid = 1'b0;
    logic        b_s_ready;
    logic [6:0]  b_s_data = '0;
    logic        b_m_valid;
    logic        b_m_ready = 1'b0;
    logic [6:0]  b_m_data;
    logic        b_m_last;
    logic        b_busy;

    bch_enc_stream u_a (
        .clk(clk), .rst_n(a_rst_n), .sync_clr(a_sync_clr),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .m_last(a_m_last), .busy(a_busy)
    );

    bch_enc_stream #(.K(63), .P(12), .GEN(12'h539), .W(7)) u_b (
        .clk(clk), .rst_n(b_rst_n), .sync_clr(b_sync_clr),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .m_last(b_m_last), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] in_q[$];
    logic [17:0] exp_q[$];
    logic [50:0] msg;
    logic [11:0] par;
    logic [17:0] held;
    logic        stalled;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Remainder by polynomial long division of m(x)*x^12 by g(x).
    function automatic logic [11:0] ref_par(input logic [50:0] m);
        logic [62:0] v;
        v = {m, 12'b0};
        for (int i = 62; i >= 12; i--) begin
            if (v[i]) v[i -: 13] = v[i -: 13] ^ 13'h1539;
        end
        return v[11:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Full codeword on instance A with m_ready held high.
    task automatic run_cw(input logic [16:0] b0, input logic [16:0] b1, input logic [16:0] b2,
                          input logic [16:0] exp_par, input string tag);
        a_m_ready = 1'b1;
        a_s_valid = 1'b1;
        a_s_data  = b0;
        #1 chk({tag, "_rdy0"}, 32'(a_s_ready), 32'd1);
        tick();
        chk({tag, "_v0"}, 32'(a_m_valid), 32'd1);
        chk({tag, "_d0"}, 32'(a_m_data), 32'(b0));
        chk({tag, "_l0"}, 32'(a_m_last), 32'd0);
        a_s_data = b1;
        tick();
        chk({tag, "_d1"}, 32'(a_m_data), 32'(b1));
        chk({tag, "_busy"}, 32'(a_busy), 32'd1);
        a_s_data = b2;
        tick();
        chk({tag, "_d2"}, 32'(a_m_data), 32'(b2));
        chk({tag, "_l2"}, 32'(a_m_last), 32'd0);
        a_s_valid = 1'b0;
        #1 chk({tag, "_rdy_par"}, 32'(a_s_ready), 32'd0);
        tick();
        chk({tag, "_par"}, 32'(a_m_data), 32'(exp_par));
        chk({tag, "_last"}, 32'(a_m_last), 32'd1);
        chk({tag, "_vpar"}, 32'(a_m_valid), 32'd1);
        chk({tag, "_rdy_next"}, 32'(a_s_ready), 32'd1);
        tick();
        chk({tag, "_idle_v"}, 32'(a_m_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(a_busy), 32'd0);
    endtask

    // Codeword on instance B: eight zero beats then lastb; optional reset in PAR.
    task automatic run7(input logic [6:0] lastb, input logic [6:0] p0, input logic [6:0] p1,
                        input bit do_rst, input string tag);
        b_m_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            b_s_valid = 1'b1;
            b_s_data  = (i == 8) ? lastb : 7'h00;
            tick();
            chk({tag, "_dv"}, 32'(b_m_valid), 32'd1);
            chk({tag, "_d"}, 32'(b_m_data), 32'((i == 8) ? lastb : 7'h00));
        end
        b_s_valid = 1'b0;
        tick();
        chk({tag, "_p0"}, 32'(b_m_data), 32'(p0));
        chk({tag, "_p0_last"}, 32'(b_m_last), 32'd0);
        if (do_rst) begin
            #1 b_rst_n = 1'b0;
            #1;
            chk({tag, "_rst_v"}, 32'(b_m_valid), 32'd0);
            chk({tag, "_rst_d"}, 32'(b_m_data), 32'd0);
            chk({tag, "_rst_l"}, 32'(b_m_last), 32'd0);
            chk({tag, "_rst_busy"}, 32'(b_busy), 32'd0);
            chk({tag, "_rst_rdy"}, 32'(b_s_ready), 32'd0);
            @(posedge clk);
            #3 b_rst_n = 1'b1;
            tick();
        end else begin
            tick();
            chk({tag, "_p1"}, 32'(b_m_data), 32'(p1));
            chk({tag, "_p1_last"}, 32'(b_m_last), 32'd1);
            tick();
            chk({tag, "_idle"}, 32'(b_m_valid), 32'd0);
        end
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        #1;
        chk("rst_mvalid", 32'(a_m_valid), 32'd0);
        chk("rst_mdata", 32'(a_m_data), 32'd0);
        chk("rst_mlast", 32'(a_m_last), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_sready", 32'(a_s_ready), 32'd0);
        @(posedge clk);
        #3 a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        #1 chk("sready_pre_clk", 32'(a_s_ready), 32'd0);
        tick();
        chk("sready_post_clk", 32'(a_s_ready), 32'd1);

        // Directed codewords, parity = {r, 5'b0}
        run_cw(17'h0, 17'h0, 17'h0, 17'h00000, "zero");
        run_cw(17'h0, 17'h0, 17'h1, 17'h0A720, "d0");
        run_cw(17'h0, 17'h0, 17'h2, 17'h14E40, "d1");
        run_cw(17'h0, 17'h0, 17'h3, 17'h1E960, "d10");

        // Directed backpressure
        a_m_ready = 1'b0;
        a_s_valid = 1'b1;
        a_s_data  = 17'h12345;
        #1 chk("bp_rdy_empty", 32'(a_s_ready), 32'd1);
        tick();
        chk("bp_d0", 32'(a_m_data), 32'h12345);
        a_s_data = 17'h0ABCD;
        #1 chk("bp_rdy_stall", 32'(a_s_ready), 32'd0);
        tick();
        chk("bp_hold", 32'(a_m_data), 32'h12345);
        chk("bp_hold_v", 32'(a_m_valid), 32'd1);
        a_m_ready = 1'b1;
        #1 chk("bp_rdy_go", 32'(a_s_ready), 32'd1);
        tick();
        chk("bp_d1", 32'(a_m_data), 32'h0ABCD);
        a_s_data = 17'h00001;
        tick();
        chk("bp_d2", 32'(a_m_data), 32'h00001);
        a_s_valid = 1'b0;
        tick();
        par = ref_par({17'h12345, 17'h0ABCD, 17'h00001});
        chk("bp_par", 32'(a_m_data), 32'({par, 5'b0}));
        chk("bp_last", 32'(a_m_last), 32'd1);
        tick();

        // Synchronous abort mid-codeword, beat presented in the same cycle
        a_s_valid = 1'b1;
        a_s_data  = 17'h1ABCD;
        tick();
        a_s_data = 17'h0F0F0;
        tick();
        chk("clr_pre", 32'(a_m_data), 32'h0F0F0);
        a_s_data   = 17'h00007;
        a_sync_clr = 1'b1;
        tick();
        chk("clr_mvalid", 32'(a_m_valid), 32'd0);
        chk("clr_busy", 32'(a_busy), 32'd0);
        chk("clr_mlast", 32'(a_m_last), 32'd0);
        chk("clr_mdata", 32'(a_m_data), 32'd0);
        chk("clr_sready", 32'(a_s_ready), 32'd0);
        a_sync_clr = 1'b0;
        a_s_valid  = 1'b0;
        tick();
        chk("clr_sready_back", 32'(a_s_ready), 32'd1);
        run_cw(17'h0, 17'h0, 17'h1, 17'h0A720, "clr_fresh");

        // Random codewords with random s_valid gaps and m_ready stalls
        for (int n = 0; n < 1000; n++) begin
            msg = {$urandom, $urandom};
            in_q.push_back(msg[50:34]);
            in_q.push_back(msg[33:17]);
            in_q.push_back(msg[16:0]);
            exp_q.push_back({1'b0, msg[50:34]});
            exp_q.push_back({1'b0, msg[33:17]});
            exp_q.push_back({1'b0, msg[16:0]});
            par = ref_par(msg);
            exp_q.push_back({1'b1, par, 5'b0});
        end
        stalled = 1'b0;
        held    = '0;
        cyc     = 0;
        while (exp_q.size() > 0 && cyc < 60000) begin
            tick();
            cyc++;
            if (stalled) begin
                chk("rnd_stall_v", 32'(a_m_valid), 32'd1);
                chk("rnd_stall_d", 32'({a_m_last, a_m_data}), 32'(held));
            end
            a_m_ready = 1'($urandom_range(0, 1));
            a_s_valid = (in_q.size() > 0) && ($urandom_range(0, 3) != 0);
            if (in_q.size() > 0) a_s_data = in_q[0];
            #1;
            if (a_m_valid && a_m_ready) begin
                chk("rnd_beat", 32'({a_m_last, a_m_data}), 32'(exp_q.pop_front()));
            end
            if (a_s_valid && a_s_ready) void'(in_q.pop_front());
            stalled = a_m_valid && !a_m_ready;
            held    = {a_m_last, a_m_data};
        end
        chk("rnd_drain", 32'(exp_q.size()), 32'd0);
        a_s_valid = 1'b0;
        a_m_ready = 1'b1;

        // Second parametrisation: 9 data beats + 2 parity beats with 2 pad bits
        tick();
        run7(7'h01, 7'h29, 7'h64, 1'b0, "w7_d0");
        run7(7'h02, 7'h53, 7'h48, 1'b1, "w7_rst");
        chk("w7_rdy_after_rst", 32'(b_s_ready), 32'd1);
        run7(7'h02, 7'h53, 7'h48, 1'b0, "w7_d1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bch_enc_stream.md
Name: bch_enc_stream

Overview:
Parametrised, streaming, systematic BCH encoder. It succeeds the fixed 63-bit combinational encoder with a W-bit-per-beat LFSR datapath that works for any code length and generator. Message beats pass through unchanged on a valid/ready output. The encoder then appends the parity beats. The block sits between the datapath and the memory/link write port wherever check bits are generated.

Parameters:
K, 51, message bits per codeword; K % W == 0 is required (elaboration error otherwise)
P, 12, parity bits, equal to the degree of the generator polynomial
GEN, 12'h539, generator coefficients x^(P-1)..x^0; the x^P term is implicit (default g = x^12+x^10+x^8+x^5+x^4+x^3+1)
W, 17, bits per beat on both stream interfaces

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
sync_clr  in  1  synchronous frame abort; highest priority after reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&s_ready
s_data  in  W  message beat; bit W-1 is the highest-degree coefficient
m_valid  out  1  output beat valid
m_ready  in  1  output beat consumed when m_valid&m_ready
m_data  out  W  codeword beat
m_last  out  1  marks the final parity beat of a codeword
busy  out  1  high from the first accepted beat until the final parity beat is consumed

Behaviour:
- Code definition:
  - m(x) = sum d[i]x^i, with d[K-1] sent first (beat 0 = d[K-1:K-W]).
  - r(x) = m(x)*x^P mod g(x).
  - The stream is the K/W message beats unchanged, followed by NP = ceil(P/W) parity beats.
  - Parity beats are sent r[P-1] first, MSB-aligned; unused low bits of the last parity beat are 0.
- Remainder register rem[P-1:0], one step per input bit, highest bit first:
  - fb = b ^ rem[P-1]
  - rem = {rem[P-2:0],1'b0} ^ (fb ? GEN : 0)
  - W steps are unrolled combinationally per accepted beat.
- Output register:
  - m_data/m_valid/m_last form a single register stage; load_ok = ~m_valid | m_ready.
  - Latency from input beat accept to that beat appearing on m_data is 1 cycle.
  - Full throughput when m_ready is held high.
- FSM states DATA and PAR; beat counter cnt has width clog2(max(K/W,NP)).
  - DATA:
    - s_ready = load_ok.
    - On accept: m_data <= s_data, m_valid <= 1, m_last <= 0, rem updated, cnt++.
    - On accepting beat K/W-1: cnt <= 0, go to PAR.
  - PAR:
    - s_ready = 0.
    - When load_ok: load parity beat cnt from the final rem, m_valid <= 1, m_last <= (cnt == NP-1), cnt++.
    - After loading the last parity beat: rem <= 0, cnt <= 0, go to DATA.
  - The first parity beat can be loaded in the cycle the last message beat is consumed, so there is no bubble.
  - The next codeword's beat 0 can be accepted in the cycle the final parity beat is consumed.
- Backpressure:
  - While m_valid & ~m_ready, m_data/m_last hold stable and s_ready = 0.
  - The rem and cnt registers do not change.
- Reset (rst_n low, asynchronous):
  - state = DATA, rem = 0, cnt = 0.
  - m_valid = 0, m_data = 0, m_last = 0, busy = 0, s_ready = 0.
  - s_ready rises on the first clock after deassertion.
- sync_clr:
  - Same register values as reset, applied on the clock edge.
  - Any in-flight codeword is discarded, including a beat presented in the same cycle.
  - No m_last is emitted for an aborted frame.
- Beat boundaries are unaffected by s_valid gaps; the remainder is a pure function of accepted beats.

Test Plan:
- Default params, all-zero message (3 beats of 17'h0), m_ready=1 -> 4 beats out: 3 zero beats, then m_data=17'h0 with m_last=1; consecutive beats, first output 1 cycle after the first accept.
- d[0]=1 only (beat 2 = 17'h00001) -> parity beat m_data = {12'h539,5'b0} = 17'h0A720, m_last=1.
- d[1]=1 only -> parity 12'hA72 (m_data = 17'h14E40); d[1:0]=2'b11 -> 12'hF4B, which checks linearity.
- Random m_ready toggling (50%) over 1000 random codewords -> m_data stable while stalled, no beats dropped or duplicated, parity matches the model.
- sync_clr asserted after beat 1 of a codeword -> m_valid=0 next cycle, busy=0; the next full codeword encodes identically to a fresh run.
- rst_n pulsed low asynchronously in PAR with m_valid=1 -> all outputs 0 immediately; re-parametrise K=63, P=12, W=7 and check 9+2 beats with 2 zero pad bits.
